// File: rtl/av_uart_tx_slave.sv
// Avalon-MM character sink for the soft core's putchar path: bytes written to
// DATA_ADDR queue in a small FIFO and leave on txd as 8N1 frames.
module av_uart_tx_slave #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] DATA_ADDR    = 16'h0100,
    parameter logic [15:0] STATUS_ADDR  = 16'h0101
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] av_address,
    input  logic        av_write,
    input  logic        av_read,
    input  logic [15:0] av_writedata,
    output logic [15:0] av_readdata,
    output logic        av_waitrequest,
    output logic        txd,
    output logic        tx_busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [1:0]    state;
    logic [15:0]   baud_cnt;
    logic          baud_end;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // the high byte of the write data carries nothing for the serializer
    logic          unused_hi;
    assign unused_hi = ^av_writedata[15:8];

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // stall is driven from the registered count only, so a same-cycle pop
    // never releases it; the write lands on the following edge
    assign av_waitrequest = av_write && (av_address == DATA_ADDR) && full;
    assign push           = av_write && (av_address == DATA_ADDR) && !full;

    assign baud_end = (baud_cnt == BAUD_MAX);
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_end));

    assign tx_busy  = (state != IDLE) || !empty;

    always_comb begin
        av_readdata = 16'h0000;
        if (av_read && (av_address == STATUS_ADDR))
            av_readdata = {8'(count), 5'b0, empty, full, tx_busy};
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= av_writedata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd      <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            // txd always shows shreg[0]; shifting exposes the next bit
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shreg <= mem[rd_ptr];
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_av_uart_tx_slave.sv
// Bench for av_uart_tx_slave: the reference model treats the serializer as a
// single server with a fixed 10-bit service time and predicts every pop edge.
module tb_av_uart_tx_slave;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FR    = 10 * CPB;
    localparam logic [15:0] DADDR = 16'h0100;
    localparam logic [15:0] SADDR = 16'h0101;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] av_address;
    logic        av_write;
    logic        av_read;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_waitrequest;
    logic        txd;
    logic        tx_busy;

    av_uart_tx_slave #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .DATA_ADDR   (DADDR),
        .STATUS_ADDR (SADDR)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .av_address    (av_address),
        .av_write      (av_write),
        .av_read       (av_read),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .av_waitrequest(av_waitrequest),
        .txd           (txd),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model: accept edges, pop edges, bytes
    int         acc_c[$];
    logic [7:0] acc_d[$];
    int         pop_c[$];
    int         last_pop;
    bit         have_pop = 0;

    function automatic int mcount(input int t);
        int n = 0;
        foreach (acc_c[i]) if (acc_c[i] <= t) n++;
        foreach (pop_c[i]) if (pop_c[i] <= t) n--;
        return n;
    endfunction

    function automatic bit mbusy(input int t);
        bit b = (mcount(t) > 0);
        foreach (pop_c[i]) if (pop_c[i] <= t && t < pop_c[i] + FR) b = 1;
        return b;
    endfunction

    function automatic logic [15:0] mstatus(input int t);
        int n = mcount(t);
        return {8'(n), 5'b0, (n == 0), (n == DEPTH), mbusy(t)};
    endfunction

    function automatic void maccept(input int e, input logic [7:0] d);
        int p = e + 1;
        if (have_pop && last_pop + FR > p) p = last_pop + FR;
        acc_c.push_back(e);
        acc_d.push_back(d);
        pop_c.push_back(p);
        last_pop = p;
        have_pop = 1;
    endfunction

    // line monitor: decodes frames at bit centres
    int         rx_c[$];
    logic [7:0] rx_d[$];
    bit         mon_act = 0;
    int         mpos;
    int         mstart;
    logic [9:0] mbits;

    always begin
        @(posedge clk); #1;
        if (!reset_n) begin
            mon_act = 0;
        end else begin
            if (!mon_act && !txd) begin
                mon_act = 1;
                mpos    = 0;
                mstart  = cyc;
            end
            if (mon_act) begin
                if (mpos % CPB == CPB / 2) mbits[mpos / CPB] = txd;
                mpos++;
                if (mpos == FR) begin
                    mon_act = 0;
                    chk("frm_start_bit", 32'(mbits[0]), 32'd0);
                    chk("frm_stop_bit", 32'(mbits[9]), 32'd1);
                    rx_c.push_back(mstart);
                    rx_d.push_back(mbits[8:1]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        int guard = 0;
        av_address   = addr;
        av_writedata = data;
        av_write     = 1'b1;
        av_read      = 1'b0;
        if (addr == DADDR) begin
            while (mcount(cyc) == DEPTH && guard < 1000) begin
                #1 chk("wait_hi", 32'(av_waitrequest), 32'd1);
                tick();
                guard++;
            end
            #1 chk("wait_lo", 32'(av_waitrequest), 32'd0);
            tick();
            maccept(cyc, data[7:0]);
        end else begin
            #1 chk("stray_wait", 32'(av_waitrequest), 32'd0);
            tick();
        end
        av_write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        av_address = addr;
        av_read    = 1'b1;
        #1 chk(tag, 32'(av_readdata), 32'(exp));
        tick();
        av_read = 1'b0;
        #1 chk("rd_idle_zero", 32'(av_readdata), 32'd0);
    endtask

    task automatic drain();
        int guard = 0;
        while (have_pop && cyc < last_pop + FR + 2 && guard < 5000) begin
            tick();
            guard++;
        end
        repeat (3) tick();
    endtask

    task automatic cmp_phase(input string tag);
        int n = (rx_d.size() < acc_d.size()) ? rx_d.size() : acc_d.size();
        chk({tag, "_nfrm"}, 32'(rx_d.size()), 32'(acc_d.size()));
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 32'(rx_d[i]), 32'(acc_d[i]));
            chk({tag, "_start"}, 32'(rx_c[i]), 32'(pop_c[i]));
        end
        acc_c.delete(); acc_d.delete(); pop_c.delete();
        rx_c.delete();  rx_d.delete();
    endtask

    initial begin
        logic [9:0] fr;
        int         a1;
        int         p0;
        reset_n      = 1'b0;
        av_address   = '0;
        av_write     = 1'b0;
        av_read      = 1'b0;
        av_writedata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_wait", 32'(av_waitrequest), 32'd0);
        chk("rst_rdata", 32'(av_readdata), 32'd0);
        reset_n = 1'b1;
        tick();
        rd("rst_status", SADDR, 16'h0004);

        // single byte: exact waveform
        do_write(DADDR, 16'hAA31);
        fr = {1'b1, 8'h31, 1'b0};
        tick();
        for (int k = 0; k < FR; k++) begin
            chk("single_bit", 32'(txd), 32'(fr[k / CPB]));
            if (k == FR - 1) chk("single_busy_last", 32'(tx_busy), 32'd1);
            tick();
        end
        chk("single_busy_end", 32'(tx_busy), 32'd0);
        drain();
        cmp_phase("single");

        // back-to-back fill with a stalled sixth write
        for (int i = 0; i < 6; i++) do_write(DADDR, 16'h0031 + 16'(i));
        a1 = acc_c[0];
        chk("b2b_w5_lat", 32'(acc_c[4] - a1), 32'd4);
        chk("b2b_w6_lat", 32'(acc_c[5] - a1), 32'(FR + 2));
        rd("mid_status", SADDR, 16'h0403);
        drain();
        for (int i = 1; i < rx_c.size(); i++)
            chk("b2b_gap", 32'(rx_c[i] - rx_c[i-1]), 32'(FR));
        cmp_phase("b2b");

        // stray accesses
        rd("stray_pre", SADDR, 16'h0004);
        do_write(16'h0200, 16'h0055);
        rd("stray_post", SADDR, 16'h0004);
        rd("stray_read", 16'h0200, 16'h0000);
        repeat (10) tick();
        chk("stray_txd", 32'(txd), 32'd1);
        cmp_phase("stray");

        // randomized traffic against the model
        for (int op = 0; op < 60; op++) begin
            int r = $urandom_range(0, 9);
            if (r < 7)       do_write(DADDR, 16'($urandom));
            else if (r == 7) do_write(16'h0200 + 16'($urandom_range(0, 255)), 16'($urandom));
            else if (r == 8) rd("rnd_status", SADDR, mstatus(cyc));
            else             repeat ($urandom_range(0, 30)) tick();
        end
        rd("rnd_status_end", SADDR, mstatus(cyc));
        drain();
        cmp_phase("rnd");

        // reset during DATA bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) do_write(DADDR, 16'($urandom));
        p0 = pop_c[0];
        while (cyc < p0 + 4 * CPB + 1) tick();
        #1 reset_n = 1'b0;
        #1;
        chk("mrst_txd", 32'(txd), 32'd1);
        chk("mrst_busy", 32'(tx_busy), 32'd0);
        repeat (3) tick();
        acc_c.delete(); acc_d.delete(); pop_c.delete();
        rx_c.delete();  rx_d.delete();
        have_pop = 0;
        reset_n  = 1'b1;
        tick();
        rd("mrst_status", SADDR, 16'h0004);
        repeat (100) tick();
        chk("mrst_nfrm", 32'(rx_d.size()), 32'd0);
        chk("mrst_txd_idle", 32'(txd), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
